// File: rtl/bram_ctrl_responder.sv
// Responder for arbiter->BRAM requests: single-port word array, fixed-latency read pipe routed to CPU or DMA.
// Optional stored-parity checking is enabled by defining BRAM_CTRL_PARITY_EN.
module bram_ctrl_responder #(
  parameter int ADDR_W = 13,
  parameter int DELAYS = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              bram_in_valid,
  input  logic              bram_wr,
  input  logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_data_in,
  input  logic              bram_reader_sel,
  output logic              cpu_rd_valid,
  output logic [31:0]       cpu_rd_data,
  output logic              dma_rd_valid,
  output logic [31:0]       dma_rd_data,
  output logic [4:0]        rd_pending,
  output logic              rd_err
);

`ifdef BRAM_CTRL_PARITY_EN
  localparam int MEM_W = 33;
`else
  localparam int MEM_W = 32;
`endif
  localparam int DEPTH = 1 << ADDR_W;

  logic [MEM_W-1:0] mem [DEPTH];
  logic [MEM_W-1:0] wr_word;
  logic             wr_acc;
  logic             rd_acc;

  // Word presented to the output stage on this edge.
  logic             ent_valid;
  logic             ent_sel;
  logic [MEM_W-1:0] ent_word;
  logic             ent_err;

  logic             cpu_rd_valid_q;
  logic             dma_rd_valid_q;
  logic [31:0]      cpu_rd_data_q;
  logic [31:0]      dma_rd_data_q;
  logic             rd_err_q;
  logic [4:0]       pending_q;
  logic [4:0]       pending_d;
  logic             pipe_exit;

  assign wr_acc = bram_in_valid & bram_wr;
  assign rd_acc = bram_in_valid & ~bram_wr;

`ifdef BRAM_CTRL_PARITY_EN
  assign wr_word = {^bram_data_in, bram_data_in};
  assign ent_err = ent_word[32] ^ (^ent_word[31:0]);
`else
  assign wr_word = bram_data_in;
  assign ent_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wr_acc) begin
      mem[bram_addr] <= wr_word;
    end
  end

  generate
    if (DELAYS == 1) begin : g_direct
      // Single-cycle latency: the output registers act as the read register.
      assign ent_valid = rd_acc;
      assign ent_sel   = bram_reader_sel;
      assign ent_word  = mem[bram_addr];
    end else begin : g_pipe
      localparam int NS = DELAYS - 1;
      logic [NS-1:0]    vld_q;
      logic [NS-1:0]    sel_q;
      logic [MEM_W-1:0] word_q [NS];

      always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
          vld_q <= '0;
          sel_q <= '0;
        end else begin
          vld_q <= (vld_q << 1) | NS'(rd_acc);
          sel_q <= (sel_q << 1) | NS'(bram_reader_sel);
        end
      end

      // Stage 0 is the registered array read; data only moves alongside a valid bit.
      always_ff @(posedge wb_clk_i) begin
        if (rd_acc) begin
          word_q[0] <= mem[bram_addr];
        end
        for (int i = 1; i < NS; i++) begin
          if (vld_q[i-1]) begin
            word_q[i] <= word_q[i-1];
          end
        end
      end

      assign ent_valid = vld_q[NS-1];
      assign ent_sel   = sel_q[NS-1];
      assign ent_word  = word_q[NS-1];
    end
  endgenerate

  assign pipe_exit = cpu_rd_valid_q | dma_rd_valid_q;

  always_comb begin
    pending_d = pending_q;
    if (rd_acc && !pipe_exit) begin
      pending_d = pending_q + 5'd1;
    end else if (!rd_acc && pipe_exit) begin
      pending_d = pending_q - 5'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cpu_rd_valid_q <= 1'b0;
      dma_rd_valid_q <= 1'b0;
      cpu_rd_data_q  <= '0;
      dma_rd_data_q  <= '0;
      rd_err_q       <= 1'b0;
      pending_q      <= '0;
    end else begin
      cpu_rd_valid_q <= ent_valid & ent_sel;
      dma_rd_valid_q <= ent_valid & ~ent_sel;
      rd_err_q       <= ent_valid & ent_err;
      pending_q      <= pending_d;
      if (ent_valid && ent_sel) begin
        cpu_rd_data_q <= ent_word[31:0];
      end
      if (ent_valid && !ent_sel) begin
        dma_rd_data_q <= ent_word[31:0];
      end
    end
  end

  assign cpu_rd_valid = cpu_rd_valid_q;
  assign dma_rd_valid = dma_rd_valid_q;
  assign cpu_rd_data  = cpu_rd_data_q;
  assign dma_rd_data  = dma_rd_data_q;
  assign rd_err       = rd_err_q;
  assign rd_pending   = pending_q;

endmodule
